// File: rtl/pc_gen_unit_if.sv
// Fetch-stage PC generator bus: hazard/redirect/RAS control in, PC state out.
// Latency: n/a (wires only).
// Backpressure: stall is the only hold; the PC side has no ready.
// Ports (slave side = pc_gen_unit):
//   in : stall, exc_valid, redirect_valid, redirect_tgt, call_valid, ret_valid
//   out: pc, pend_valid, ras_count, ras_underflow
interface pc_gen_unit_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             exc_valid;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_tgt;
  logic             call_valid;
  logic             ret_valid;

  logic [WIDTH-1:0] pc;
  logic             pend_valid;
  logic [CNT_W-1:0] ras_count;
  logic             ras_underflow;

  modport master (
    output stall, exc_valid, redirect_valid, redirect_tgt, call_valid, ret_valid,
    input  pc, pend_valid, ras_count, ras_underflow
  );

  modport slave (
    input  stall, exc_valid, redirect_valid, redirect_tgt, call_valid, ret_valid,
    output pc, pend_valid, ras_count, ras_underflow
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Registered next-PC select (exception/redirect/buffered redirect/RAS/PC+4) with call/return stack.
// Latency: every source reaches pc one cycle after it is sampled; a buffered redirect one cycle after stall falls.
// Backpressure: stall holds pc and RAS; a redirect seen during stall is parked in a one-entry buffer.
// Ports: clk, rst (sync, active-high); bus (pc_gen_unit_if.slave) carries the control inputs and pc,
//        pend_valid, ras_count, ras_underflow outputs.
module pc_gen_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0040_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0040_0004),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_gen_unit_if.slave  bus
);
  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ras_uflow_q, ras_uflow_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  // ras_ptr points at the next slot to write; top of stack is ras_ptr-1.
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] redir_tgt;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] push_ptr;
  logic [CNT_W-1:0] push_cnt;

  // Ring arithmetic that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_MAX : p - 1'b1;
  endfunction

  always_comb begin
    pc_inc      = pc_q + WIDTH'(4);
    redir_tgt   = bus.redirect_tgt & ~WIDTH'(3);
    top_idx     = ptr_dec(ras_ptr_q);

    pc_d        = pc_inc;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    ras_d       = ras_q;
    ras_ptr_d   = ras_ptr_q;
    ras_cnt_d   = ras_cnt_q;
    ras_uflow_d = 1'b0;
    push_ptr    = ras_ptr_q;
    push_cnt    = ras_cnt_q;

    if (bus.exc_valid) begin
      pc_d       = EXC_VECTOR;
      pend_vld_d = 1'b0;
    end else if (bus.redirect_valid && bus.stall) begin
      // Park the redirect; a later one during the same stall replaces it.
      pc_d       = pc_q;
      pend_tgt_d = redir_tgt;
      pend_vld_d = 1'b1;
    end else if (bus.redirect_valid) begin
      pc_d       = redir_tgt;
      pend_vld_d = 1'b0;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (pend_vld_q) begin
      pc_d       = pend_tgt_q;
      pend_vld_d = 1'b0;
    end else begin
      // Pop first so a call+ret pair replaces the top entry in place.
      if (bus.ret_valid) begin
        if (ras_cnt_q != '0) begin
          pc_d     = ras_q[top_idx];
          push_ptr = top_idx;
          push_cnt = ras_cnt_q - 1'b1;
        end else begin
          ras_uflow_d = 1'b1;
        end
      end
      if (bus.call_valid) begin
        // When full, the write slot is the oldest entry, so it is overwritten.
        ras_d[push_ptr] = pc_inc;
        ras_ptr_d       = ptr_inc(push_ptr);
        ras_cnt_d       = (push_cnt == CNT_MAX) ? push_cnt : push_cnt + 1'b1;
      end else begin
        ras_ptr_d = push_ptr;
        ras_cnt_d = push_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      pend_vld_q  <= 1'b0;
      pend_tgt_q  <= '0;
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      ras_uflow_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      pend_vld_q  <= pend_vld_d;
      pend_tgt_q  <= pend_tgt_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
      ras_uflow_q <= ras_uflow_d;
      ras_q       <= ras_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pend_valid    = pend_vld_q;
  assign bus.ras_count     = ras_cnt_q;
  assign bus.ras_underflow = ras_uflow_q;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: table of per-cycle {inputs, expected outputs} plus hand-written corner sequences.
// Latency: each vector is checked one cycle after it is driven.
// Backpressure: exercised through stall sequences in the table.
module tb_pc_gen_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_gen_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

  pc_gen_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0040_0000), .EXC_VECTOR(32'h0040_0004), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic        rst, stall, exc, rdv;
    logic [31:0] tgt;
    logic        call, ret;
    logic [31:0] pc;
    logic        pend;
    logic [2:0]  cnt;
    logic        uf;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic e, input logic rd,
                              input logic [31:0] t, input logic c, input logic rt,
                              input logic [31:0] p, input logic pv, input logic [2:0] n,
                              input logic u);
    vec_t x;
    x.rst = r; x.stall = s; x.exc = e; x.rdv = rd; x.tgt = t; x.call = c; x.ret = rt;
    x.pc = p; x.pend = pv; x.cnt = n; x.uf = u;
    return x;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic run_vec(input vec_t t);
    vec_t e;
    @(negedge clk);
    rst                = t.rst;
    bus.stall          = t.stall;
    bus.exc_valid      = t.exc;
    bus.redirect_valid = t.rdv;
    bus.redirect_tgt   = t.tgt;
    bus.call_valid     = t.call;
    bus.ret_valid      = t.ret;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL step%0d: scoreboard empty", step);
    end else begin
      e = exp_q.pop_front();
      if (bus.pc !== e.pc || bus.pend_valid !== e.pend ||
          bus.ras_count !== e.cnt || bus.ras_underflow !== e.uf) begin
        errors++;
        $display("FAIL step%0d: got pc=%h pend=%b cnt=%0d uf=%b, want pc=%h pend=%b cnt=%0d uf=%b",
                 step, bus.pc, bus.pend_valid, bus.ras_count, bus.ras_underflow,
                 e.pc, e.pend, e.cnt, e.uf);
      end
    end
    step++;
  endtask

  task automatic idle(input logic [31:0] p, input logic [2:0] n);
    run_vec(mk(0,0,0,0,32'h0,0,0, p,0,n,0));
  endtask

  initial begin
    bus.stall = 0; bus.exc_valid = 0; bus.redirect_valid = 0;
    bus.redirect_tgt = '0; bus.call_valid = 0; bus.ret_valid = 0;

    //            rst stl exc rdv tgt           cal ret  pc            pnd cnt uf
    // reset and sequential fetch
    tbl.push_back(mk(1,0,0,0,32'h0,          0,0, 32'h0040_0000,0,0,0));
    tbl.push_back(mk(1,0,0,0,32'h0,          0,0, 32'h0040_0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_0004,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_0008,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_000C,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_0010,0,0,0));
    // stall with redirect in the second stall cycle
    tbl.push_back(mk(0,1,0,0,32'h0,          0,0, 32'h0040_0010,0,0,0));
    tbl.push_back(mk(0,1,0,1,32'h0040_0100,  0,0, 32'h0040_0010,1,0,0));
    tbl.push_back(mk(0,1,0,0,32'h0,          0,0, 32'h0040_0010,1,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_0100,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_0104,0,0,0));
    // newer parked redirect replaces older one, low bits dropped
    tbl.push_back(mk(0,1,0,1,32'h0040_0400,  0,0, 32'h0040_0104,1,0,0));
    tbl.push_back(mk(0,1,0,1,32'h0040_0503,  0,0, 32'h0040_0104,1,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_0500,0,0,0));
    // exception beats stall, redirect and parked redirect
    tbl.push_back(mk(0,1,0,1,32'h0040_0600,  0,0, 32'h0040_0500,1,0,0));
    tbl.push_back(mk(0,1,1,1,32'h0040_0700,  0,0, 32'h0040_0004,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_0008,0,0,0));
    // five calls into a four-deep RAS
    tbl.push_back(mk(0,0,0,1,32'h0000_0100,  0,0, 32'h0000_0100,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0000_0104,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h0000_0200,  0,0, 32'h0000_0200,0,1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0000_0204,0,2,0));
    tbl.push_back(mk(0,0,0,1,32'h0000_0300,  0,0, 32'h0000_0300,0,2,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0000_0304,0,3,0));
    tbl.push_back(mk(0,0,0,1,32'h0000_0400,  0,0, 32'h0000_0400,0,3,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0000_0404,0,4,0));
    tbl.push_back(mk(0,0,0,1,32'h0000_0500,  0,0, 32'h0000_0500,0,4,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0000_0504,0,4,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0000_0504,0,3,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0000_0404,0,2,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0000_0304,0,1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0000_0204,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0000_0208,0,0,1));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0000_020C,0,0,0));
    // redirect outranks ret; RAS untouched
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0000_0210,0,1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0000_0214,0,2,0));
    tbl.push_back(mk(0,0,0,1,32'h0040_0200,  0,1, 32'h0040_0200,0,2,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0000_0214,0,1,0));
    // call+ret: pop 0x210, push 0x218 in its place
    tbl.push_back(mk(0,0,0,0,32'h0,          1,1, 32'h0000_0210,0,1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0000_0218,0,0,0));
    // RAS survives an exception
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0000_021C,0,1,0));
    tbl.push_back(mk(0,0,1,0,32'h0,          0,0, 32'h0040_0004,0,1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0000_021C,0,0,0));
    // PC wrap and target alignment
    tbl.push_back(mk(0,0,0,1,32'hFFFF_FFF8,  0,0, 32'hFFFF_FFF8,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'hFFFF_FFFC,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0000_0000,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h0040_0103,  0,0, 32'h0040_0100,0,0,0));
    // reset overrides everything and clears RAS and parked redirect
    tbl.push_back(mk(0,0,0,0,32'h0,          1,0, 32'h0040_0104,0,1,0));
    tbl.push_back(mk(0,1,0,1,32'h0040_0800,  0,0, 32'h0040_0104,1,1,0));
    tbl.push_back(mk(1,1,1,1,32'h0040_0900,  1,1, 32'h0040_0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,1, 32'h0040_0004,0,0,1));
    tbl.push_back(mk(0,0,0,0,32'h0,          0,0, 32'h0040_0008,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
    end

    // Long stall: parked redirect stays put until stall falls.
    run_vec(mk(0,1,0,1,32'h0040_0900, 0,0, 32'h0040_0008,1,0,0));
    for (int i = 0; i < 6; i++) begin
      run_vec(mk(0,1,0,0,32'h0, 0,0, 32'h0040_0008,1,0,0));
    end
    idle(32'h0040_0900, 3'd0);

    // call+ret on an empty stack: underflow, fall through, then push.
    run_vec(mk(0,0,0,0,32'h0, 1,1, 32'h0040_0904,0,1,1));
    run_vec(mk(0,0,0,0,32'h0, 0,1, 32'h0040_0904,0,0,0));
    idle(32'h0040_0908, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
